// File: rtl/ber_checker.sv
// Bit-error-rate checker: auto-finds tx-to-rx lag, then counts compared bits and errors while locked.
// Latency: a compare is visible on bit_cnt_o/err_cnt_o/err_o one cycle later.
// Backpressure: none; en_i qualifies both streams and nothing advances when it is low.
module ber_checker #(
    parameter int MAX_LAG  = 64,
    parameter int SYNC_LEN = 32,
    parameter int WIN      = 64,
    parameter int LOSS_TH  = 8,
    parameter int CW       = 32,
    localparam int LW      = $clog2(MAX_LAG + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          tx_bit_i,
    input  logic          rx_bit_i,
    input  logic          clear_i,
    output logic          locked_o,
    output logic [LW-1:0] lag_o,
    output logic [CW-1:0] bit_cnt_o,
    output logic [CW-1:0] err_cnt_o,
    output logic          err_o,
    output logic          lost_o
);
    localparam int MW = $clog2(SYNC_LEN + 1);
    localparam int PW = $clog2(WIN);
    localparam int EW = $clog2(WIN + 1);

    localparam logic [LW-1:0] LAG_ONE   = LW'(1);
    localparam logic [LW-1:0] LAG_MAX   = LW'(MAX_LAG);
    localparam logic [MW-1:0] SYNC_LAST = MW'(SYNC_LEN - 1);
    localparam logic [PW-1:0] WIN_LAST  = PW'(WIN - 1);
    localparam logic [EW-1:0] LOSS_V    = EW'(LOSS_TH);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state;
    logic [MAX_LAG:1] hist;
    logic [LW-1:0]    lag;
    logic [LW-1:0]    fill;
    logic [MW-1:0]    match_cnt;
    logic [PW-1:0]    win_pos;
    logic [EW-1:0]    win_err;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    err_cnt;

    logic          can_cmp;
    logic          mism;
    logic [EW-1:0] win_err_nxt;
    logic          loss;

    // hist[L] holds the tx bit from L enabled cycles ago; compares see the pre-shift contents.
    assign can_cmp     = (fill >= lag);
    assign mism        = rx_bit_i ^ hist[lag];
    assign win_err_nxt = win_err + {{(EW-1){1'b0}}, mism};
    assign loss        = (win_err_nxt >= LOSS_V);

    assign locked_o  = (state == ST_LOCKED);
    assign lag_o     = lag;
    assign bit_cnt_o = bit_cnt;
    assign err_cnt_o = err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_SEARCH;
            hist      <= '0;
            lag       <= LAG_ONE;
            fill      <= '0;
            match_cnt <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            err_o     <= 1'b0;
            lost_o    <= 1'b0;
        end else begin
            err_o  <= 1'b0;
            lost_o <= 1'b0;
            if (en_i) begin
                hist <= {hist[MAX_LAG-1:1], tx_bit_i};
                if (fill != LAG_MAX) begin
                    fill <= fill + 1'b1;
                end
                if (state == ST_SEARCH) begin
                    if (can_cmp) begin
                        if (!mism) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == SYNC_LAST) begin
                                state <= ST_LOCKED;
                            end
                        end else begin
                            match_cnt <= '0;
                            lag       <= (lag == LAG_MAX) ? LAG_ONE : lag + 1'b1;
                        end
                    end
                end else begin
                    err_o <= mism;
                    if (bit_cnt != '1) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (mism && (err_cnt != '1)) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    // Loss outranks a window wrap on the same compare.
                    if (loss) begin
                        state     <= ST_SEARCH;
                        lag       <= LAG_ONE;
                        match_cnt <= '0;
                        win_pos   <= '0;
                        win_err   <= '0;
                        lost_o    <= 1'b1;
                    end else if (win_pos == WIN_LAST) begin
                        win_pos <= '0;
                        win_err <= '0;
                    end else begin
                        win_pos <= win_pos + 1'b1;
                        win_err <= win_err_nxt;
                    end
                end
            end
            if (clear_i) begin
                bit_cnt <= '0;
                err_cnt <= '0;
                win_pos <= '0;
                win_err <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ber_checker.sv
// Directed-sequence bench with randomized PRBS data, checked every cycle against a queue-based model.
module tb_ber_checker;
    localparam int MAX_LAG  = 64;
    localparam int SYNC_LEN = 32;
    localparam int WIN      = 64;
    localparam int LOSS_TH  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, tx_bit = 1'b0, rx_bit = 1'b0, rx4 = 1'b0, clear = 1'b0;
    logic        locked, err, lost;
    logic [6:0]  lag;
    logic [31:0] bits, errs;
    logic        locked4, err4, lost4;
    logic [6:0]  lag4;
    logic [3:0]  bits4, errs4;

    int checks = 0;
    int failures = 0;

    ber_checker dut (
        .clk(clk), .rst(rst), .en_i(en), .tx_bit_i(tx_bit), .rx_bit_i(rx_bit),
        .clear_i(clear), .locked_o(locked), .lag_o(lag), .bit_cnt_o(bits),
        .err_cnt_o(errs), .err_o(err), .lost_o(lost)
    );

    ber_checker #(.CW(4), .LOSS_TH(64)) dut4 (
        .clk(clk), .rst(rst), .en_i(en), .tx_bit_i(tx_bit), .rx_bit_i(rx4),
        .clear_i(clear), .locked_o(locked4), .lag_o(lag4), .bit_cnt_o(bits4),
        .err_cnt_o(errs4), .err_o(err4), .lost_o(lost4)
    );

    always #5 clk = ~clk;

    // Reference model: log of every enabled tx bit, plus lock/window bookkeeping.
    bit     m_txlog[$];
    int     m_nen;
    bit     m_locked, m_err, m_lost;
    int     m_lag, m_match, m_wpos, m_werr;
    longint m_bits, m_errs;
    logic [6:0] prbs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_txlog.delete();
        m_nen = 0; m_locked = 0; m_err = 0; m_lost = 0;
        m_lag = 1; m_match = 0; m_wpos = 0; m_werr = 0; m_bits = 0; m_errs = 0;
    endtask

    task automatic model_step(input bit e, input bit tx, input bit rx, input bit clr);
        bit h, mis;
        int nw;
        m_err = 0;
        m_lost = 0;
        if (e) begin
            if (m_nen >= m_lag) begin
                h = m_txlog[m_nen - m_lag];
                mis = (rx != h);
                if (!m_locked) begin
                    if (!mis) begin
                        m_match++;
                        if (m_match == SYNC_LEN) m_locked = 1;
                    end else begin
                        m_match = 0;
                        m_lag = (m_lag == MAX_LAG) ? 1 : m_lag + 1;
                    end
                end else begin
                    m_err = mis;
                    m_bits++;
                    if (mis) m_errs++;
                    nw = m_werr + int'(mis);
                    if (nw >= LOSS_TH) begin
                        m_locked = 0; m_lag = 1; m_match = 0; m_wpos = 0; m_werr = 0; m_lost = 1;
                    end else if (m_wpos == WIN - 1) begin
                        m_wpos = 0; m_werr = 0;
                    end else begin
                        m_wpos++; m_werr = nw;
                    end
                end
            end
            m_txlog.push_back(tx);
            m_nen++;
        end
        if (clr) begin
            m_bits = 0; m_errs = 0; m_wpos = 0; m_werr = 0;
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "locked"}, 64'(locked), 64'(m_locked));
        chk({pfx, "lag"}, 64'(lag), 64'(m_lag));
        chk({pfx, "bit_cnt"}, 64'(bits), 64'(m_bits));
        chk({pfx, "err_cnt"}, 64'(errs), 64'(m_errs));
        chk({pfx, "err"}, 64'(err), 64'(m_err));
        chk({pfx, "lost"}, 64'(lost), 64'(m_lost));
    endtask

    // One clock: rx is tx delayed d enabled cycles, optionally inverted per instance.
    task automatic step(input int d, input bit e, input bit inv, input bit inv4, input bit clr);
        bit t, rc;
        if (e) begin
            t = prbs[6];
            prbs = {prbs[5:0], prbs[6] ^ prbs[5]};
            rc = (m_nen >= d) ? m_txlog[m_nen - d] : 1'($urandom);
        end else begin
            t = 1'($urandom);
            rc = 1'($urandom);
        end
        en = e; tx_bit = t; rx_bit = rc ^ inv; rx4 = rc ^ inv4; clear = clr;
        @(posedge clk);
        model_step(e, t, rc ^ inv, clr);
        #1;
        check_all("");
    endtask

    task automatic wait_lock(input int d, input int budget, input bit toggle, input string tag);
        int n = 0;
        while (!locked && n < budget) begin
            step(d, toggle ? ((n % 2) == 0) : 1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk(tag, 64'(locked), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_");
        chk("rst_lag4", 64'(lag4), 64'd1);
        chk("rst_locked4", 64'(locked4), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int errp, lostp;
        prbs = 7'($urandom_range(1, 127));
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("init_");
        chk("init_lag_one", 64'(lag), 64'd1);
        rst = 1'b1;

        // Continuous enable, lag 20.
        wait_lock(20, 600, 1'b0, "lock20");
        chk("lag20", 64'(lag), 64'd20);
        repeat (100) step(20, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clean_err_cnt", 64'(errs), 64'd0);
        chk("clean_bit_cnt", 64'(bits), 64'd100);

        // One inverted bit every 16 locked bits.
        step(20, 1'b0, 1'b0, 1'b0, 1'b1);
        errp = 0; lostp = 0;
        for (int k = 0; k < 256; k++) begin
            step(20, 1'b1, (k % 16) == 15, 1'b0, 1'b0);
            errp += int'(err);
            lostp += int'(lost);
        end
        chk("sparse_err_cnt", 64'(errs), 64'd16);
        chk("sparse_bit_cnt", 64'(bits), 64'd256);
        chk("sparse_err_pulses", 64'(errp), 64'd16);
        chk("sparse_lost_pulses", 64'(lostp), 64'd0);

        // Eight consecutive errors force loss of lock.
        for (int k = 0; k < 8; k++) step(20, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("loss_lost", 64'(lost), 64'd1);
        chk("loss_lag", 64'(lag), 64'd1);
        chk("loss_locked", 64'(locked), 64'd0);
        chk("loss_err_cnt", 64'(errs), 64'd24);
        step(20, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("held_bit_cnt", 64'(bits), 64'd264);
        chk("held_lost", 64'(lost), 64'd0);
        wait_lock(20, 800, 1'b0, "relock20");
        chk("relock_lag", 64'(lag), 64'd20);

        // Clear coinciding with a mismatch compare.
        repeat (5) step(20, 1'b1, 1'b0, 1'b0, 1'b0);
        step(20, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clear_err_cnt", 64'(errs), 64'd0);
        chk("clear_bit_cnt", 64'(bits), 64'd0);
        chk("clear_locked", 64'(locked), 64'd1);

        // Toggling enable, lag 5.
        do_reset();
        wait_lock(5, 1600, 1'b1, "lock5");
        chk("lag5", 64'(lag), 64'd5);
        step(5, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle_bit_cnt", 64'(bits), 64'd0);
        chk("idle_err", 64'(err), 64'd0);
        step(5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("en_bit_cnt", 64'(bits), 64'd1);

        // Narrow counters saturate; every bit wrong on the CW=4 instance.
        do_reset();
        wait_lock(20, 600, 1'b0, "lock_sat");
        chk("sat_locked4", 64'(locked4), 64'd1);
        chk("sat_bits4_start", 64'(bits4), 64'd0);
        for (int i = 1; i <= 64; i++) begin
            step(20, 1'b1, 1'b0, 1'b1, 1'b0);
            if (i == 14) chk("sat_err4_14", 64'(errs4), 64'd14);
            if (i == 20) begin
                chk("sat_err4_20", 64'(errs4), 64'd15);
                chk("sat_bits4_20", 64'(bits4), 64'd15);
            end
            if (i == 63) begin
                chk("sat_locked4_63", 64'(locked4), 64'd1);
                chk("sat_err4_63", 64'(errs4), 64'd15);
            end
        end
        chk("sat_lost4", 64'(lost4), 64'd1);
        chk("sat_unlocked4", 64'(locked4), 64'd0);
        chk("sat_lag4", 64'(lag4), 64'd1);
        chk("sat_err4_held", 64'(errs4), 64'd15);

        // Reset while the main instance is locked.
        chk("prerst_locked", 64'(locked), 64'd1);
        do_reset();
        repeat (3) step(20, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ber_checker.md
Name: ber_checker

Overview:
- Bit-error-rate checker that sits directly downstream of the Viterbi decoder in the tx/rx test harness.
- Consumes the encoder input stream (tx reference) and the decoder output stream (rx), and finds the decoder's pipeline lag automatically.
- Once locked, counts compared bits and bit errors, and flags loss of lock.
- Used in place of manual waveform inspection to score decoder performance against channel error rate N.

Parameters:
- MAX_LAG, 64, largest tx-to-rx lag searched, in enabled cycles (>=2).
- SYNC_LEN, 32, consecutive matches required to declare lock.
- WIN, 64, locked-mode monitoring window length, in compared bits.
- LOSS_TH, 8, errors within one window that force loss of lock (1..WIN).
- CW, 32, width of the bit and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en_i  in  1  qualifies both streams this cycle; tx and rx advance together.
- tx_bit_i  in  1  bit entering the encoder this cycle.
- rx_bit_i  in  1  bit leaving the decoder this cycle.
- clear_i  in  1  synchronous clear of bit_cnt_o, err_cnt_o and window counters; lock state kept.
- locked_o  out  1  high while in LOCKED.
- lag_o  out  $clog2(MAX_LAG+1)  current candidate lag (SEARCH) or locked lag (LOCKED).
- bit_cnt_o  out  CW  bits compared while locked.
- err_cnt_o  out  CW  mismatches while locked.
- err_o  out  1  one-cycle pulse: mismatch on the previous enabled locked compare.
- lost_o  out  1  one-cycle pulse on LOCKED->SEARCH transition.

Behaviour:
- Reset (rst low, asynchronous): state SEARCH, lag=1, match count 0, history fill 0, history contents 0. All outputs 0, except lag_o=1.
- Nothing changes on cycles where en_i=0, apart from clear_i handling and err_o/lost_o returning to 0.
- History: MAX_LAG-deep shift register of tx_bit_i, shifted on each enabled cycle.
  - hist(L) is the tx bit captured L enabled cycles before the current one.
  - Compares use pre-shift contents.
  - A fill counter saturates at MAX_LAG.
- SEARCH, per enabled cycle:
  - If fill < lag: no compare; hold lag and match count.
  - On match (rx_bit_i == hist(lag)): match count +1. When it reaches SYNC_LEN, go to LOCKED next cycle; locked_o=1 that cycle; lag frozen.
  - On mismatch: match count=0; lag+1, wrapping MAX_LAG->1.
  - Counters do not advance in SEARCH.
- LOCKED, per enabled cycle:
  - Compare rx_bit_i to hist(lag).
  - bit_cnt_o +1 and, on mismatch, err_cnt_o +1, both registered (visible next cycle). Each counter saturates at all-ones.
  - err_o=1 on the cycle after a mismatch.
  - Window position counter runs 0..WIN-1. The window error counter increments on each mismatch.
  - If the window error count reaches LOSS_TH: next cycle state=SEARCH, lag=1, match count=0, window counters=0, lost_o=1 for one cycle, locked_o=0. bit_cnt_o and err_cnt_o are held.
  - At window position WIN-1 without loss: window counters reset to 0.
  - Loss takes priority over window wrap on the same compare.
- clear_i=1: bit_cnt_o, err_cnt_o and window counters go to 0 next cycle.
  - clear_i wins over a simultaneous increment.
  - State, lag and history are unaffected.
- Reset asserted mid-LOCKED: immediate return to reset values. History refills from scratch after release.
- Latency: compare to counter/err_o visibility is 1 cycle.

Test Plan:
- PRBS7 tx, rx = tx delayed 20 enabled cycles, en_i=1 continuously. Required: lag_o=20 and locked_o=1 after the 32nd consecutive match at lag 20; then err_cnt_o=0 and bit_cnt_o increments by 1 per cycle.
- Same setup with rx inverted once every 16 locked bits. Required: err_o pulses every 16 cycles; after 256 locked bits, err_cnt_o=16 and bit_cnt_o=256; no lost_o.
- Locked at lag 20, then 8 consecutive inverted rx bits. Required: lost_o pulse after the 8th error, lag_o=1, locked_o=0, counters held. The bench then observes relock at lag 20.
- en_i toggling 1/0 every cycle with a delay of 5 enabled cycles. Required: lock at lag 5, identical to the continuous-enable case; no state change on en_i=0 cycles.
- Locked, then assert clear_i on the same cycle as a mismatch compare. Required: next cycle err_cnt_o=0, bit_cnt_o=0, locked_o stays 1.
- CW=4, locked with every bit wrong and LOSS_TH=WIN=64: err_cnt_o saturates at 15 and holds. Separately, rst pulsed low while locked: all outputs return to reset values immediately.
